// File: rtl/map_task_scheduler.sv
// ----------------------------------------------------------------------------
// map_task_scheduler
//   Job-level scheduler for the MapReduce NoC. A job descriptor (base address,
//   task count) is latched on scheduler_wen_i. The job is split into
//   job_num_tasks_i chunks of CHUNK_SIZE bytes. The chunks are offered
//   round-robin to idle mappers. The block counts completions, starts the
//   reducer and reports job completion. Only one job is in flight at a time.
//
//   Optional feature: define SCHED_PERF_CNT_EN to add job_cycles_o, which
//   counts the busy cycles of the current or most recent job.
//
// Ports
//   clk_i            clock
//   rst_i            synchronous reset, active-high
//   scheduler_wen_i  job-start strobe; samples job_base_i / job_num_tasks_i
//   job_base_i       address of chunk 0
//   job_num_tasks_i  number of map tasks in the job
//   task_valid_o     one-hot task offer to a mapper
//   task_ready_i     per-mapper accept of the offer
//   task_id_o        index of the offered task
//   task_addr_o      job_base + task_id*CHUNK_SIZE (mod 2^ADDR_W)
//   map_done_i       per-mapper pulse: current task finished
//   reduce_start_o   pulse: all maps done, start the reducer
//   reduce_done_i    pulse from the reducer
//   busy_o           high whenever a job is in progress
//   job_done_o       pulse on job completion
//   job_cycles_o     (SCHED_PERF_CNT_EN only) busy-cycle count of the job
//
// States
//   IDLE     | waiting for a job strobe
//   DISPATCH | offering tasks to idle mappers
//   DRAIN    | all tasks issued, waiting for map completions
//   REDUCE   | reducer started, waiting for reduce_done_i
//   DONE     | single cycle, job_done_o high
// ----------------------------------------------------------------------------
module map_task_scheduler #(
  parameter int NUM_MAPPERS = 4,
  parameter int ADDR_W      = 16,
  parameter int TASK_W      = 8,
  parameter int CHUNK_SIZE  = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   scheduler_wen_i,
  input  logic [ADDR_W-1:0]      job_base_i,
  input  logic [TASK_W-1:0]      job_num_tasks_i,
  output logic [NUM_MAPPERS-1:0] task_valid_o,
  input  logic [NUM_MAPPERS-1:0] task_ready_i,
  output logic [TASK_W-1:0]      task_id_o,
  output logic [ADDR_W-1:0]      task_addr_o,
  input  logic [NUM_MAPPERS-1:0] map_done_i,
  output logic                   reduce_start_o,
  input  logic                   reduce_done_i,
  output logic                   busy_o,
  output logic                   job_done_o
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]            job_cycles_o
`endif
);

  localparam int PTR_W = (NUM_MAPPERS > 1) ? $clog2(NUM_MAPPERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DISPATCH = 3'd1,
    S_DRAIN    = 3'd2,
    S_REDUCE   = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]      base_q;
  logic [TASK_W-1:0]      num_q;
  logic [TASK_W-1:0]      issued_q;
  logic [TASK_W-1:0]      done_q;
  logic [NUM_MAPPERS-1:0] mbusy_q;
  logic [PTR_W-1:0]       rr_q;
  logic [NUM_MAPPERS-1:0] offer_valid_q;
  logic [PTR_W-1:0]       offer_idx_q;
  logic [TASK_W-1:0]      task_id_q;
  logic [ADDR_W-1:0]      task_addr_q;
  logic                   reduce_start_q;

  logic                   job_accept;
  logic                   accept;
  logic [NUM_MAPPERS-1:0] done_hits;
  logic [TASK_W-1:0]      done_inc;
  logic                   sel_found;
  logic [PTR_W-1:0]       sel_idx;
  logic                   offer_sel;
  logic [NUM_MAPPERS-1:0] offer_onehot;
  logic [NUM_MAPPERS-1:0] accept_onehot;
  logic [ADDR_W-1:0]      offer_addr;
  logic [PTR_W-1:0]       rr_next;

  assign job_accept    = (state_q == S_IDLE) && scheduler_wen_i;
  assign accept        = |(offer_valid_q & task_ready_i);
  assign done_hits     = map_done_i & mbusy_q;
  assign offer_onehot  = NUM_MAPPERS'(1) << sel_idx;
  assign accept_onehot = NUM_MAPPERS'(1) << offer_idx_q;
  assign offer_addr    = base_q + (ADDR_W'(issued_q) * ADDR_W'(CHUNK_SIZE));
  assign rr_next       = (offer_idx_q == PTR_W'(NUM_MAPPERS - 1)) ? '0 : offer_idx_q + 1'b1;

  // Completions from several mappers in the same cycle all count.
  always_comb begin
    done_inc = '0;
    for (int i = 0; i < NUM_MAPPERS; i++) begin
      done_inc = done_inc + TASK_W'(done_hits[i]);
    end
  end

  // First idle mapper at or after the round-robin pointer, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NUM_MAPPERS; k++) begin
      idx = (int'(rr_q) + k) % NUM_MAPPERS;
      if (!sel_found && !mbusy_q[idx]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(idx);
      end
    end
  end

  // A new offer is only formed while none is pending, so after a handshake
  // at least one idle cycle passes before the next offer appears.
  assign offer_sel = (state_q == S_DISPATCH) && (offer_valid_q == '0) &&
                     (issued_q != num_q) && sel_found;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (scheduler_wen_i) begin
          state_d = (job_num_tasks_i == '0) ? S_DONE : S_DISPATCH;
        end
      end
      S_DISPATCH: if (issued_q == num_q) state_d = S_DRAIN;
      S_DRAIN:    if (done_q == num_q)   state_d = S_REDUCE;
      S_REDUCE:   if (reduce_done_i)     state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    task_valid_o   = offer_valid_q;
    task_id_o      = task_id_q;
    task_addr_o    = task_addr_q;
    reduce_start_o = reduce_start_q;
    busy_o         = (state_q != S_IDLE);
    job_done_o     = (state_q == S_DONE);
  end

  // Datapath: descriptor, counters, mapper occupancy and the offer register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q         <= '0;
      num_q          <= '0;
      issued_q       <= '0;
      done_q         <= '0;
      mbusy_q        <= '0;
      rr_q           <= '0;
      offer_valid_q  <= '0;
      offer_idx_q    <= '0;
      task_id_q      <= '0;
      task_addr_q    <= '0;
      reduce_start_q <= 1'b0;
    end else begin
      if (job_accept) begin
        base_q   <= job_base_i;
        num_q    <= job_num_tasks_i;
        issued_q <= '0;
        done_q   <= '0;
      end else begin
        if (accept) issued_q <= issued_q + 1'b1;
        done_q <= done_q + done_inc;
      end

      mbusy_q <= (mbusy_q & ~done_hits) | (accept ? accept_onehot : '0);

      if (accept) begin
        offer_valid_q <= '0;
        rr_q          <= rr_next;
      end else if (offer_sel) begin
        offer_valid_q <= offer_onehot;
        offer_idx_q   <= sel_idx;
        task_id_q     <= issued_q;
        task_addr_q   <= offer_addr;
      end

      reduce_start_q <= (state_q == S_DRAIN) && (state_d == S_REDUCE);
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] job_cycles_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      job_cycles_q <= '0;
    end else if (job_accept) begin
      job_cycles_q <= '0;
    end else if ((state_q != S_IDLE) && (job_cycles_q != 32'hFFFF_FFFF)) begin
      job_cycles_q <= job_cycles_q + 32'd1;
    end
  end

  assign job_cycles_o = job_cycles_q;
`endif

endmodule

// File: tb/tb_map_task_scheduler.sv
module tb_map_task_scheduler;

  logic        clk;
  logic        rst;
  logic        wen;
  logic [15:0] job_base;
  logic [7:0]  job_num;
  logic [3:0]  task_valid;
  logic [3:0]  task_ready;
  logic [7:0]  task_id;
  logic [15:0] task_addr;
  logic [3:0]  map_done;
  logic        reduce_start;
  logic        reduce_done;
  logic        busy;
  logic        job_done;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] job_cycles;
`endif

  map_task_scheduler #(
    .NUM_MAPPERS(4), .ADDR_W(16), .TASK_W(8), .CHUNK_SIZE(64)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .scheduler_wen_i(wen),
    .job_base_i(job_base),
    .job_num_tasks_i(job_num),
    .task_valid_o(task_valid),
    .task_ready_i(task_ready),
    .task_id_o(task_id),
    .task_addr_o(task_addr),
    .map_done_i(map_done),
    .reduce_start_o(reduce_start),
    .reduce_done_i(reduce_done),
    .busy_o(busy),
    .job_done_o(job_done)
`ifdef SCHED_PERF_CNT_EN
    ,
    .job_cycles_o(job_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tst;
    int          mapper;
    logic [7:0]  id;
    logic [15:0] addr;
  } exp_t;

  typedef struct {
    int          mapper;
    logic [7:0]  id;
    logic [15:0] addr;
  } acc_t;

  localparam int NTBL = 16;
  exp_t tbl[NTBL];
  acc_t acc_q[$];

  int checks;
  int failures;
  int tmr[4];
  logic [3:0] hold;
  int rd_tmr;
  logic auto_reduce;
  int rs_cnt;
  int jd_cnt;
  int busy_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock: record handshakes, advance the mapper and reducer models.
  task automatic tick();
    logic [3:0] acc;
    acc_t a;
    acc = task_valid & task_ready;
    if (acc != 4'b0) begin
      a.mapper = 0;
      for (int i = 0; i < 4; i++) if (acc[i]) a.mapper = i;
      a.id   = task_id;
      a.addr = task_addr;
      acc_q.push_back(a);
    end
    @(posedge clk);
    #1;
    map_done    = 4'b0;
    reduce_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) tmr[i] = 3;
      else if (tmr[i] > 0) begin
        tmr[i]--;
        if (tmr[i] == 0 && !hold[i]) map_done[i] = 1'b1;
      end
    end
    if (rd_tmr > 0) begin
      rd_tmr--;
      if (rd_tmr == 0) reduce_done = 1'b1;
    end
    if (reduce_start) begin
      rs_cnt++;
      if (auto_reduce) rd_tmr = 2;
    end
    if (job_done) jd_cnt++;
    if (busy) busy_cnt++;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) tmr[i] = 0;
    hold        = 4'b0;
    rd_tmr      = 0;
    auto_reduce = 1'b1;
    rs_cnt      = 0;
    jd_cnt      = 0;
    busy_cnt    = 0;
    map_done    = 4'b0;
    reduce_done = 1'b0;
    task_ready  = 4'hF;
    acc_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wen = 1'b0;
    clear_model();
    tick();
    tick();
    rst = 1'b0;
    rs_cnt = 0;
    jd_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic start_job(input logic [15:0] base, input logic [7:0] n);
    job_base = base;
    job_num  = n;
    wen      = 1'b1;
    busy_cnt = 0;
    tick();
    wen      = 1'b0;
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(name, busy, 1'b0);
  endtask

  task automatic check_queue(input int tag);
    int n_exp;
    int k;
    n_exp = 0;
    for (int e = 0; e < NTBL; e++) if (tbl[e].tst == tag) n_exp++;
    chk($sformatf("t%0d_accept_count", tag), acc_q.size(), n_exp);
    k = 0;
    for (int e = 0; e < NTBL; e++) begin
      if (tbl[e].tst == tag) begin
        if (k < acc_q.size()) begin
          chk($sformatf("t%0d_task%0d_mapper", tag, k), acc_q[k].mapper, tbl[e].mapper);
          chk($sformatf("t%0d_task%0d_id", tag, k), acc_q[k].id, tbl[e].id);
          chk($sformatf("t%0d_task%0d_addr", tag, k), acc_q[k].addr, tbl[e].addr);
        end
        k++;
      end
    end
  endtask

  initial begin
    logic [3:0]  v0;
    logic [7:0]  id0;
    logic [15:0] a0;
    int          n;

    tbl[0]  = '{1, 0, 8'd0, 16'h0100};
    tbl[1]  = '{1, 1, 8'd1, 16'h0140};
    tbl[2]  = '{1, 2, 8'd2, 16'h0180};
    tbl[3]  = '{1, 3, 8'd3, 16'h01C0};
    tbl[4]  = '{2, 0, 8'd0, 16'h0200};
    tbl[5]  = '{2, 1, 8'd1, 16'h0240};
    tbl[6]  = '{2, 2, 8'd2, 16'h0280};
    tbl[7]  = '{2, 3, 8'd3, 16'h02C0};
    tbl[8]  = '{2, 0, 8'd4, 16'h0300};
    tbl[9]  = '{2, 2, 8'd5, 16'h0340};
    tbl[10] = '{4, 0, 8'd0, 16'h0300};
    tbl[11] = '{5, 0, 8'd0, 16'h0400};
    tbl[12] = '{5, 1, 8'd1, 16'h0440};
    tbl[13] = '{7, 0, 8'd0, 16'h0500};
    tbl[14] = '{6, 0, 8'd0, 16'hFFC0};
    tbl[15] = '{6, 1, 8'd1, 16'h0000};

    checks   = 0;
    failures = 0;
    job_base = 16'h0;
    job_num  = 8'h0;

    // Reset state
    do_reset();
    chk("rst_task_valid", task_valid, 4'b0);
    chk("rst_task_id", task_id, 8'h0);
    chk("rst_task_addr", task_addr, 16'h0);
    chk("rst_reduce_start", reduce_start, 1'b0);
    chk("rst_job_done", job_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
`ifdef SCHED_PERF_CNT_EN
    chk("rst_job_cycles", job_cycles, 32'd0);
`endif

    // 1: four tasks, mappers always ready
    start_job(16'h0100, 8'd4);
    chk("t1_busy_after_wen", busy, 1'b1);
    chk("t1_no_offer_in_select_cycle", task_valid, 4'b0);
    tick();
    chk("t1_first_offer_valid", task_valid, 4'b0001);
    chk("t1_first_offer_addr", task_addr, 16'h0100);
    run_until_idle("t1_idle_timeout", 200);
    check_queue(1);
    chk("t1_reduce_start_pulses", rs_cnt, 1);
    chk("t1_job_done_cycles", jd_cnt, 1);

    // 2: six tasks, mapper 1 never finishes until released
    do_reset();
    hold[1] = 1'b1;
    start_job(16'h0200, 8'd6);
    for (int i = 0; i < 40; i++) tick();
    reduce_done = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    chk("t2_drain_busy", busy, 1'b1);
    chk("t2_drain_no_reduce_start", rs_cnt, 0);
    chk("t2_drain_no_offer", task_valid, 4'b0);
    chk("t2_drain_no_job_done", jd_cnt, 0);
    map_done[1] = 1'b1;
    hold[1] = 1'b0;
    tick();
    run_until_idle("t2_idle_timeout", 200);
    check_queue(2);
    chk("t2_reduce_start_pulses", rs_cnt, 1);
    chk("t2_job_done_cycles", jd_cnt, 1);

    // 3: zero-task job
    do_reset();
    start_job(16'h1234, 8'd0);
    chk("t3_job_done_high", job_done, 1'b1);
    chk("t3_busy_in_done", busy, 1'b1);
    chk("t3_no_offer", task_valid, 4'b0);
    tick();
    chk("t3_job_done_low", job_done, 1'b0);
    chk("t3_busy_low", busy, 1'b0);
    chk("t3_no_reduce_start", rs_cnt, 0);
    chk("t3_no_accepts", acc_q.size(), 0);

    // 4: offer stalled by task_ready low for five cycles
    do_reset();
    task_ready = 4'b0;
    start_job(16'h0300, 8'd1);
    tick();
    v0  = task_valid;
    id0 = task_id;
    a0  = task_addr;
    chk("t4_offer_valid", v0, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t4_hold%0d_valid", i), task_valid, v0);
      chk($sformatf("t4_hold%0d_id", i), task_id, id0);
      chk($sformatf("t4_hold%0d_addr", i), task_addr, a0);
    end
    task_ready = 4'hF;
    tick();
    chk("t4_valid_drops", task_valid, 4'b0);
    run_until_idle("t4_idle_timeout", 200);
    check_queue(4);

    // 5: second strobe ignored, then reset while in REDUCE
    do_reset();
    auto_reduce = 1'b0;
    start_job(16'h0400, 8'd2);
    tick();
    job_base = 16'h0800;
    job_num  = 8'd5;
    wen      = 1'b1;
    tick();
    wen      = 1'b0;
    n = 0;
    while (rs_cnt == 0 && n < 100) begin
      tick();
      n++;
    end
    chk("t5_reduce_start_seen", rs_cnt, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("t5_reduce_holds_busy", busy, 1'b1);
    check_queue(5);
    do_reset();
    chk("t5_rst_task_valid", task_valid, 4'b0);
    chk("t5_rst_task_id", task_id, 8'h0);
    chk("t5_rst_task_addr", task_addr, 16'h0);
    chk("t5_rst_reduce_start", reduce_start, 1'b0);
    chk("t5_rst_job_done", job_done, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
`ifdef SCHED_PERF_CNT_EN
    chk("t5_rst_job_cycles", job_cycles, 32'd0);
`endif
    start_job(16'h0500, 8'd1);
    tick();
    chk("t5_new_offer_valid", task_valid, 4'b0001);
    chk("t5_new_offer_id", task_id, 8'd0);
    chk("t5_new_offer_addr", task_addr, 16'h0500);
    run_until_idle("t5_idle_timeout", 200);
    check_queue(7);
    chk("t5_new_job_done_cycles", jd_cnt, 1);

    // 6: address wrap at the top of the address space
    do_reset();
    start_job(16'hFFC0, 8'd2);
    run_until_idle("t6_idle_timeout", 200);
    check_queue(6);
    chk("t6_job_done_cycles", jd_cnt, 1);
`ifdef SCHED_PERF_CNT_EN
    chk("t6_job_cycles", job_cycles, busy_cnt);
    tick();
    tick();
    chk("t6_job_cycles_hold", job_cycles, busy_cnt);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
